// File: rtl/pim_result_aggregator.sv
// pim_result_aggregator: gathers per-unit PIM result tiles into a full matrix and streams it out one row per beat.
// Define PIM_AGG_ERR_EN to compile in the sticky protocol-error flag; otherwise err is tied low.
package types;
    localparam int WIDTH       = 32;
    localparam int CHUNK_SIZE  = 2;
    localparam int MATRIX_SIZE = 4;
endpackage

module pim_result_aggregator #(
    parameter int WIDTH       = types::WIDTH,
    parameter int CHUNK_SIZE  = types::CHUNK_SIZE,
    parameter int MATRIX_SIZE = types::MATRIX_SIZE,
    parameter int TILES       = MATRIX_SIZE / CHUNK_SIZE,
    parameter int NUM_UNITS   = TILES ** 2,
    localparam int ROW_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               start,
    input  logic [NUM_UNITS-1:0][CHUNK_SIZE**2-1:0][WIDTH-1:0] unit_result,
    input  logic [NUM_UNITS-1:0]                               unit_result_valid,
    output logic [MATRIX_SIZE-1:0][WIDTH-1:0]                  out_row,
    output logic [ROW_W-1:0]                                   out_row_idx,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic                                               out_last,
    output logic                                               done,
    output logic                                               err
);
    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]                                         state_q, state_d;
    logic [NUM_UNITS-1:0]                               mask_q, mask_d;
    logic [ROW_W-1:0]                                   row_q, row_d;
    logic                                               done_q, done_d;
    logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][WIDTH-1:0] buf_q, buf_d;

    assign out_valid   = state_q == S_DRAIN;
    assign out_row_idx = row_q;
    assign out_last    = out_valid && (row_q == ROW_W'(MATRIX_SIZE - 1));
    assign out_row     = out_valid ? buf_q[row_q] : '0;
    assign done        = done_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        row_d   = row_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        if (state_q == S_COLLECT) begin
            if (start) begin
                mask_d = '0;
            end else begin
                // only first arrival per tile is kept; repeats leave the buffer untouched
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (unit_result_valid[u] && !mask_q[u]) begin
                        for (int k = 0; k < CHUNK_SIZE**2; k++)
                            buf_d[(u / TILES) * CHUNK_SIZE + k / CHUNK_SIZE][(u % TILES) * CHUNK_SIZE + k % CHUNK_SIZE] = unit_result[u][k];
                        mask_d[u] = 1'b1;
                    end
                end
                if (&mask_d) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end
            end
        end else if (state_q == S_DRAIN) begin
            if (out_ready) begin
                row_d   = out_last ? '0 : row_q + 1'b1;
                state_d = out_last ? S_DONE : S_DRAIN;
                done_d  = out_last;
            end
        end else if (start) begin
            state_d = S_COLLECT;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_COLLECT;
            mask_q  <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) buf_q <= buf_d;

`ifdef PIM_AGG_ERR_EN
    logic err_q, err_d;
    // a start in COLLECT discards same-cycle tiles without flagging them
    always_comb err_d = err_q | ((state_q == S_COLLECT) ? (!start && |(unit_result_valid & mask_q)) : |unit_result_valid);
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pim_result_aggregator.sv
// tb_pim_result_aggregator: directed checks of tile collection, row drain, backpressure, errors and reset abort.
module tb_pim_result_aggregator;
    localparam int W = 32, C = 2, M = 4, N = 4;

    logic clk = 1'b0;
    logic rst, start, out_ready, out_valid, out_last, done, err;
    logic [N-1:0][C*C-1:0][W-1:0] unit_result;
    logic [N-1:0] unit_result_valid;
    logic [M-1:0][W-1:0] out_row;
    logic [1:0] out_row_idx;
    int vectors = 0, miscompares = 0;
`ifdef PIM_AGG_ERR_EN
    logic exp_err = 1'b1;
`else
    logic exp_err = 1'b0;
`endif
    int tbl [4][4] = '{'{0, 1, 16, 17}, '{2, 3, 18, 19}, '{32, 33, 48, 49}, '{34, 35, 50, 51}};

    always #5 clk = ~clk;

    pim_result_aggregator #(.WIDTH(W), .CHUNK_SIZE(C), .MATRIX_SIZE(M), .NUM_UNITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .unit_result(unit_result),
        .unit_result_valid(unit_result_valid), .out_row(out_row), .out_row_idx(out_row_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done), .err(err)
    );

    function automatic logic [M-1:0][W-1:0] std_row(input int r, input int off);
        for (int c = 0; c < M; c++) std_row[c] = W'(tbl[r][c] + off);
    endfunction

    task automatic pulse(input logic [N-1:0] mask, input int off);
        @(negedge clk);
        for (int u = 0; u < N; u++)
            for (int k = 0; k < C*C; k++)
                if (mask[u]) unit_result[u][k] = W'(off + 16*u + k);
        unit_result_valid = mask;
        @(negedge clk);
        unit_result_valid = '0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; unit_result = '0; unit_result_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++; if ({out_valid, out_last, done, err} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, out_last, done, err}); end
        vectors++; if (out_row !== '0) begin miscompares++; $display("FAIL reset_row: got %h expected 0", out_row); end
        vectors++; if (out_row_idx !== 2'd0) begin miscompares++; $display("FAIL reset_idx: got %0d expected 0", out_row_idx); end
    endtask

    task automatic test_sequential();
        pulse(4'b0001, 0); pulse(4'b0010, 0); pulse(4'b0100, 0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL seq_early_valid: got %b expected 0", out_valid); end
        pulse(4'b1000, 0);
        for (int r = 0; r < M; r++) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL seq_valid r%0d: got %b expected 1", r, out_valid); end
            vectors++; if (out_row_idx !== 2'(r)) begin miscompares++; $display("FAIL seq_idx r%0d: got %0d expected %0d", r, out_row_idx, r); end
            vectors++; if (out_row !== std_row(r, 0)) begin miscompares++; $display("FAIL seq_row r%0d: got %h expected %h", r, out_row, std_row(r, 0)); end
            vectors++; if (out_last !== (r == M-1)) begin miscompares++; $display("FAIL seq_last r%0d: got %b expected %b", r, out_last, r == M-1); end
            vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL seq_done_early r%0d: got %b expected 0", r, done); end
            @(negedge clk);
        end
        vectors++; if ({done, out_valid} !== 2'b10) begin miscompares++; $display("FAIL seq_done: got done,valid=%b expected 10", {done, out_valid}); end
        vectors++; if (out_row !== '0) begin miscompares++; $display("FAIL seq_row_zero: got %h expected 0", out_row); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL seq_done_width: got %b expected 0", done); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL seq_err: got %b expected 0", err); end
    endtask

    task automatic test_simultaneous();
        do_start();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sim_pre_valid: got %b expected 0", out_valid); end
        pulse(4'b1111, 0);
        for (int r = 0; r < M; r++) begin
            vectors++; if (out_valid !== 1'b1 || out_row_idx !== 2'(r)) begin miscompares++; $display("FAIL sim_beat r%0d: got valid=%b idx=%0d expected 1/%0d", r, out_valid, out_row_idx, r); end
            vectors++; if (out_row !== std_row(r, 0)) begin miscompares++; $display("FAIL sim_row r%0d: got %h expected %h", r, out_row, std_row(r, 0)); end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sim_done: got %b expected 1", done); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        logic [3:0] pat = 4'b1001;
        do_start();
        pulse(4'b1111, 0);
        for (int cyc = 0; cyc < 40 && idx < M; cyc++) begin
            vectors++; if (out_valid !== 1'b1 || out_row_idx !== 2'(idx)) begin miscompares++; $display("FAIL bp_beat c%0d: got valid=%b idx=%0d expected 1/%0d", cyc, out_valid, out_row_idx, idx); end
            vectors++; if (out_row !== std_row(idx, 0)) begin miscompares++; $display("FAIL bp_row c%0d: got %h expected %h", cyc, out_row, std_row(idx, 0)); end
            out_ready = pat[cyc % 4];
            if (out_ready) idx++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        vectors++; if (idx !== M) begin miscompares++; $display("FAIL bp_rows_accepted: got %0d expected %0d", idx, M); end
        vectors++; if ({done, out_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_done: got done,valid=%b expected 10", {done, out_valid}); end
    endtask

    task automatic test_duplicate();
        logic [M-1:0][W-1:0] er;
        do_start();
        pulse(4'b0001, 0);
        @(negedge clk); unit_result[1] = {C*C{32'h0000AAAA}}; unit_result_valid = 4'b0010;
        @(negedge clk); unit_result[1] = {C*C{32'h0000BBBB}}; unit_result_valid = 4'b0010;
        @(negedge clk); unit_result_valid = '0;
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL dup_err: got %b expected %b", err, exp_err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dup_valid: got %b expected 0", out_valid); end
        pulse(4'b1100, 0);
        for (int r = 0; r < M; r++) begin
            er = std_row(r, 0);
            if (r < 2) begin er[2] = 32'hAAAA; er[3] = 32'hAAAA; end
            vectors++; if (out_valid !== 1'b1 || out_row !== er) begin miscompares++; $display("FAIL dup_row r%0d: got valid=%b %h expected %h", r, out_valid, out_row, er); end
            @(negedge clk);
        end
    endtask

    task automatic test_late_restart();
        do_rst();
        vectors++; if (err !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL late_rst: got err=%b valid=%b expected 0/0", err, out_valid); end
        pulse(4'b1111, 0);
        for (int r = 0; r < M; r++) begin
            vectors++; if (out_valid !== 1'b1 || out_row_idx !== 2'(r) || out_row !== std_row(r, 0)) begin miscompares++; $display("FAIL late_row r%0d: got valid=%b idx=%0d %h expected %h", r, out_valid, out_row_idx, out_row, std_row(r, 0)); end
            if (r == 0) begin unit_result[2] = {C*C{32'h0000DEAD}}; unit_result_valid = 4'b0100; end
            @(negedge clk);
            unit_result_valid = '0;
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL late_done: got %b expected 1", done); end
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL late_err: got %b expected %b", err, exp_err); end
        do_start();
        pulse(4'b1111, 256);
        vectors++; if (out_valid !== 1'b1 || out_row !== std_row(0, 256)) begin miscompares++; $display("FAIL restart_row: got valid=%b %h expected %h", out_valid, out_row, std_row(0, 256)); end
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL restart_err_sticky: got %b expected %b", err, exp_err); end
    endtask

    task automatic test_abort_reset();
        do_rst();
        vectors++; if (out_valid !== 1'b0 || out_row !== '0 || out_row_idx !== 2'd0) begin miscompares++; $display("FAIL abort_drain: got valid=%b idx=%0d %h expected 0", out_valid, out_row_idx, out_row); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL abort_err: got %b expected 0", err); end
        pulse(4'b0011, 0);
        do_rst();
        pulse(4'b1100, 0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_partial_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_partial_hold: got %b expected 0", out_valid); end
        pulse(4'b0011, 4096);
        for (int r = 0; r < M; r++) begin
            vectors++; if (out_valid !== 1'b1 || out_row !== std_row(r, r < 2 ? 4096 : 0)) begin miscompares++; $display("FAIL abort_row r%0d: got valid=%b %h expected %h", r, out_valid, out_row, std_row(r, r < 2 ? 4096 : 0)); end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL abort_done: got %b expected 1", done); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_simultaneous();
        test_backpressure();
        test_duplicate();
        test_late_restart();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pim_result_aggregator.md
# pim_result_aggregator

Collects the per-unit result tiles produced by the PIM array and assembles them into the full MATRIX_SIZE×MATRIX_SIZE product. It sits between the PIM units and the host-side readout. It is the consumer of each unit's `result`/`result_valid` interface. Once every tile has arrived, it streams the assembled matrix out one row per beat over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, default `types::WIDTH`: element width in bits.
- `CHUNK_SIZE`, default `types::CHUNK_SIZE`: tile edge length.
- `MATRIX_SIZE`, default `types::MATRIX_SIZE`: full matrix edge length; must be a multiple of `CHUNK_SIZE`.
- `TILES`, default `MATRIX_SIZE/CHUNK_SIZE`: tiles per matrix edge (derived, not overridden).
- `NUM_UNITS`, default `TILES**2`: number of PIM units, one tile each.

Ports:
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: clears the collected tiles and begins a new collection.
- `unit_result` in `[NUM_UNITS-1:0][CHUNK_SIZE**2-1:0]`×`WIDTH`: per-unit tile, row-major (index = i*CHUNK_SIZE + j).
- `unit_result_valid` in `[NUM_UNITS-1:0]`: one-cycle pulse per unit when its tile is valid.
- `out_row` out `[MATRIX_SIZE-1:0]`×`WIDTH`: one assembled matrix row.
- `out_row_idx` out `$clog2(MATRIX_SIZE)` (minimum 1): index of the row on `out_row`.
- `out_valid` out 1: `out_row` is valid.
- `out_ready` in 1: downstream accepts the current beat.
- `out_last` out 1: asserted with the final row (`out_row_idx == MATRIX_SIZE-1`).
- `done` out 1: one-cycle pulse after the final row is accepted.
- `err` out 1: sticky protocol-error flag (see Configuration).

## Operation
- Unit u owns tile (tr, tc) = (u / TILES, u % TILES). Element k of unit u goes to matrix element [tr*CHUNK_SIZE + k/CHUNK_SIZE][tc*CHUNK_SIZE + k%CHUNK_SIZE].
- Internal state:
  - a full-matrix register buffer;
  - `fill_mask[NUM_UNITS-1:0]`;
  - a row counter;
  - an FSM with three states: COLLECT, DRAIN, DONE.
- COLLECT:
  - For each u with `unit_result_valid[u]` set and `fill_mask[u]==0`, the tile is written to the buffer and `fill_mask[u]` is set.
  - Any number of units may be valid in the same cycle; all are captured in parallel.
  - When the mask becomes all-ones, the next state is DRAIN and the row counter is 0.
- DRAIN:
  - `out_valid` = 1 and `out_row` = buffer[row counter].
  - On `out_valid && out_ready`, the row counter increments.
  - On acceptance with `out_last`, the next state is DONE.
  - `out_row` and `out_row_idx` hold stable while `out_ready` = 0.
- DONE:
  - `out_valid` = 0.
  - `start` moves the FSM to COLLECT with `fill_mask` cleared.
- `start` in COLLECT clears `fill_mask` and the FSM stays in COLLECT. `start` takes priority over `unit_result_valid` in the same cycle; those tiles are discarded. `start` in DRAIN is ignored.
- Protocol errors:
  - a valid pulse for an already-filled tile in COLLECT;
  - any valid pulse in DRAIN or DONE.
  - In both cases the data is discarded and the buffer is not modified.
- `out_row` is driven to all zeros whenever `out_valid` = 0.

## Timing
- Reset values: FSM=COLLECT, `fill_mask`=0, row counter=0, `out_valid`=0, `out_row_idx`=0, `out_last`=0, `done`=0, `err`=0, `out_row`=0. Buffer contents are not reset.
- Tile capture: data is written on the edge where `unit_result_valid[u]` is sampled high.
- The last tile captured on edge N gives `out_valid`=1 in cycle N+1, presenting row 0.
- Row throughput is one row per cycle with `out_ready` held high. A full drain takes MATRIX_SIZE cycles.
- The final handshake on edge M gives `done`=1 for exactly cycle M+1, with FSM=DONE.
- `rst` mid-DRAIN aborts the drain: `out_valid` goes to 0 on the next cycle and all partial state is lost.
- `err` sets on the edge after the offending pulse and is cleared only by `rst`.

## Configuration
- `PIM_AGG_ERR_EN` defined: error detection is compiled in and `err` behaves as described above.
- Not defined: the detection logic is removed and `err` is tied to 0. Discarding of duplicate or late tiles is unchanged.

## Test plan
Configuration for all scenarios: WIDTH=32, CHUNK_SIZE=2, MATRIX_SIZE=4, NUM_UNITS=4, `out_ready`=1 unless stated.
- Sequential tiles: units 0..3 pulse on consecutive cycles, unit u element k = 16u+k → rows beat 0..3 are {0,1,16,17}, {2,3,18,19}, {32,33,48,49}, {34,35,50,51}; `out_last` is set on row 3; `done` pulses once.
- Simultaneous tiles: all 4 units valid in one cycle → `out_valid` rises on the next cycle and the data matches the sequential-tiles case.
- Backpressure: `out_ready` toggles 1,0,0,1,… → each row is held stable while stalled, no row is skipped or repeated, and `out_row_idx` runs 0,1,2,3.
- Duplicate tile: unit 1 pulses twice with 0xAAAA then 0xBBBB → row data carries 0xAAAA; `err`=1 with the macro, 0 without.
- Late tile and restart: unit 2 pulses during DRAIN → the drain is unaffected and `err`=1. `start` in DONE → COLLECT; the next collection works normally, while `err` stays 1 because only `rst` clears it.
- Abort by reset: `rst` after 2 tiles → `fill_mask`=0; 4 new tiles are then required before `out_valid`.
